sram_arbiter: RTL

- Shares one synchronous single-port SRAM between the IF-stage fetch requester and the EXE/MEM-stage data requester, so the core runs on a unified memory.
- Uses a req/addr_ok/data_ok handshake and allows one outstanding transaction.
- Data requests win by default; a starvation counter forces an instruction grant after a bounded number of consecutive data wins.
- Sits between the pipeline stages and the top-level memory port in `mycpu_top`.

---
 rtl/sram_arbiter_pkg.sv | 16 +
 rtl/sram_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the unified-memory arbiter: FSM states, owner
// encodings and counter widths.
package sram_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam logic ArbOwnerInst = 1'b0;
    localparam logic ArbOwnerData = 1'b1;

    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] CntMax = '1;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between the fetch and data requesters
// using a req/addr_ok/data_ok handshake with a single outstanding transaction.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int unsigned MEM_LAT    = 1,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        inst_req_i,
    input  logic        inst_wr_i,
    input  logic [3:0]  inst_wstrb_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] inst_wdata_i,
    output logic        inst_addr_ok_o,
    output logic        inst_data_ok_o,
    output logic [31:0] inst_rdata_o,
    input  logic        data_req_i,
    input  logic        data_wr_i,
    input  logic [3:0]  data_wstrb_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_addr_ok_o,
    output logic        data_data_ok_o,
    output logic [31:0] data_rdata_o,
    output logic        mem_en_o,
    output logic [3:0]  mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i,
    output logic        arb_owner_o
);

    localparam logic [CntW-1:0] LatInit   = CntW'(MEM_LAT);
    localparam logic [CntW-1:0] StarveLim = CntW'(STARVE_MAX);
    localparam logic [CntW-1:0] CntOne    = CntW'(1);

    arb_state_e      state_q, state_d;
    logic            owner_q, owner_d;
    logic            cur_wr_q, cur_wr_d;
    logic [CntW-1:0] lat_cnt_q, lat_cnt_d;
    logic [CntW-1:0] starve_cnt_q, starve_cnt_d;

    logic resp, eligible, grant_inst, grant_data;

    always_comb begin
        resp       = (state_q == StBusy) && (lat_cnt_q == CntOne);
        // Gating with reset forces every combinational output low while reset is held.
        eligible   = resetn_i && ((state_q == StIdle) || resp);
        grant_inst = eligible && inst_req_i && (!data_req_i || (starve_cnt_q >= StarveLim));
        grant_data = eligible && data_req_i && !grant_inst;
    end

    always_comb begin
        inst_addr_ok_o = grant_inst;
        data_addr_ok_o = grant_data;
        mem_en_o       = grant_inst || grant_data;
        mem_we_o       = '0;
        mem_addr_o     = '0;
        mem_wdata_o    = '0;
        if (grant_inst) begin
            mem_we_o    = inst_wr_i ? inst_wstrb_i : 4'b0000;
            mem_addr_o  = inst_addr_i;
            mem_wdata_o = inst_wdata_i;
        end else if (grant_data) begin
            mem_we_o    = data_wr_i ? data_wstrb_i : 4'b0000;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
        inst_data_ok_o = resp && (owner_q == ArbOwnerInst);
        data_data_ok_o = resp && (owner_q == ArbOwnerData);
        inst_rdata_o   = (inst_data_ok_o && !cur_wr_q) ? mem_rdata_i : '0;
        data_rdata_o   = (data_data_ok_o && !cur_wr_q) ? mem_rdata_i : '0;
        arb_owner_o    = owner_q;
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        cur_wr_d     = cur_wr_q;
        lat_cnt_d    = lat_cnt_q;
        starve_cnt_d = starve_cnt_q;

        if (grant_inst || grant_data) begin
            state_d   = StBusy;
            lat_cnt_d = LatInit;
            owner_d   = grant_data ? ArbOwnerData : ArbOwnerInst;
            cur_wr_d  = grant_data ? data_wr_i : inst_wr_i;
        end else if (state_q == StBusy) begin
            lat_cnt_d = lat_cnt_q - CntOne;
            if (resp) begin
                state_d = StIdle;
            end
        end

        // Counts data wins taken while fetch is waiting.
        if (!inst_req_i || grant_inst) begin
            starve_cnt_d = '0;
        end else if (grant_data && (starve_cnt_q != CntMax)) begin
            starve_cnt_d = starve_cnt_q + CntOne;
        end
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= StIdle;
            owner_q      <= ArbOwnerInst;
            cur_wr_q     <= 1'b0;
            lat_cnt_q    <= '0;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cur_wr_q     <= cur_wr_d;
            lat_cnt_q    <= lat_cnt_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

endmodule
